// File: rtl/tpose_row_serialize.sv
// Row serializer behind the 8-lane IDCT transpose: joins one sample per lane,
// converts each to a saturated pixel, and streams the row out lane 0 first.
module tpose_row_serialize #(
    parameter int W_IN         = 16,
    parameter int W_OUT        = 8,
    parameter int SHIFT        = 0,
    parameter int LEVEL        = 128,
    parameter int ROWS_PER_BLK = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic signed [W_IN-1:0] a0_d,
    input  logic                   a0_e,
    input  logic                   a0_v,
    output logic                   a0_b,
    input  logic signed [W_IN-1:0] a1_d,
    input  logic                   a1_e,
    input  logic                   a1_v,
    output logic                   a1_b,
    input  logic signed [W_IN-1:0] a2_d,
    input  logic                   a2_e,
    input  logic                   a2_v,
    output logic                   a2_b,
    input  logic signed [W_IN-1:0] a3_d,
    input  logic                   a3_e,
    input  logic                   a3_v,
    output logic                   a3_b,
    input  logic signed [W_IN-1:0] a4_d,
    input  logic                   a4_e,
    input  logic                   a4_v,
    output logic                   a4_b,
    input  logic signed [W_IN-1:0] a5_d,
    input  logic                   a5_e,
    input  logic                   a5_v,
    output logic                   a5_b,
    input  logic signed [W_IN-1:0] a6_d,
    input  logic                   a6_e,
    input  logic                   a6_v,
    output logic                   a6_b,
    input  logic signed [W_IN-1:0] a7_d,
    input  logic                   a7_e,
    input  logic                   a7_v,
    output logic                   a7_b,
    output logic [W_OUT-1:0]       o_d,
    output logic                   o_e,
    output logic                   o_v,
    input  logic                   o_b,
    output logic                   err,
    output logic [15:0]            blk_cnt
);

    localparam int RND = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
    localparam logic signed [W_IN+1:0] RND_E   = (W_IN+2)'(RND);
    localparam logic signed [W_IN+1:0] LEVEL_E = (W_IN+2)'(LEVEL);
    localparam logic signed [W_IN+1:0] MAX_E   = (W_IN+2)'((1 << W_OUT) - 1);
    localparam int RC_W = (ROWS_PER_BLK > 1) ? $clog2(ROWS_PER_BLK) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROWS_PER_BLK - 1);

    typedef enum logic [1:0] {COLLECT, EMIT, EOS, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [RC_W-1:0]   row_cnt_q, row_cnt_d;
    logic [15:0]       blk_cnt_q, blk_cnt_d;
    logic              err_q, err_d;
    logic [W_OUT-1:0]  pix_q [8];
    logic [W_OUT-1:0]  pix_d [8];

    logic signed [W_IN-1:0] lane_d [8];
    logic [7:0]             lane_v, lane_e;
    logic                   rowready, eosready, mismatch;
    logic                   can_take, take, row_done, lane_b;

    // Round-half-up shift, level shift and clamp, all in W_IN+2 bits.
    function automatic logic [W_OUT-1:0] sat_pix(input logic signed [W_IN-1:0] x);
        logic signed [W_IN+1:0] xe;
        logic signed [W_IN+1:0] y;
        xe = {{2{x[W_IN-1]}}, x};
        y  = ((xe + RND_E) >>> SHIFT) + LEVEL_E;
        if (y[W_IN+1])
            return '0;
        else if (y > MAX_E)
            return '1;
        else
            return y[W_OUT-1:0];
    endfunction

    assign lane_d[0] = a0_d;
    assign lane_d[1] = a1_d;
    assign lane_d[2] = a2_d;
    assign lane_d[3] = a3_d;
    assign lane_d[4] = a4_d;
    assign lane_d[5] = a5_d;
    assign lane_d[6] = a6_d;
    assign lane_d[7] = a7_d;
    assign lane_v = {a7_v, a6_v, a5_v, a4_v, a3_v, a2_v, a1_v, a0_v};
    assign lane_e = {a7_e, a6_e, a5_e, a4_e, a3_e, a2_e, a1_e, a0_e};

    assign rowready = (&lane_v) & ~(|lane_e);
    assign eosready = (&lane_v) & (&lane_e);
    assign mismatch = (&lane_v) & (|lane_e) & ~(&lane_e);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        row_cnt_d = row_cnt_q;
        blk_cnt_d = blk_cnt_q;
        err_d     = err_q;
        for (int i = 0; i < 8; i++) pix_d[i] = pix_q[i];
        o_v       = 1'b0;
        o_e       = 1'b0;
        o_d       = '0;
        can_take  = 1'b0;
        take      = 1'b0;
        row_done  = 1'b0;

        case (state_q)
            COLLECT: can_take = 1'b1;
            EMIT: begin
                o_v = 1'b1;
                o_d = pix_q[idx_q];
                if (!o_b) begin
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        row_done = 1'b1;
                        can_take = 1'b1;
                        state_d  = COLLECT;
                        idx_d    = 3'd0;
                    end
                end
            end
            EOS: begin
                o_v = 1'b1;
                o_e = 1'b1;
                if (!o_b) state_d = DONE;
            end
            default: ;
        endcase

        if (row_done) begin
            if (row_cnt_q == RC_LAST) begin
                row_cnt_d = '0;
                blk_cnt_d = blk_cnt_q + 16'd1;
            end else begin
                row_cnt_d = row_cnt_q + 1'b1;
            end
        end

        // Once err is set nothing is ever consumed again until reset.
        if (can_take && !err_q) begin
            if (rowready) begin
                take    = 1'b1;
                state_d = EMIT;
                idx_d   = 3'd0;
                for (int i = 0; i < 8; i++) pix_d[i] = sat_pix(lane_d[i]);
            end else if (eosready) begin
                take    = 1'b1;
                state_d = EOS;
            end else if (mismatch) begin
                err_d = 1'b1;
            end
        end

        lane_b = ~(take & reset);
    end

    assign a0_b = lane_b;
    assign a1_b = lane_b;
    assign a2_b = lane_b;
    assign a3_b = lane_b;
    assign a4_b = lane_b;
    assign a5_b = lane_b;
    assign a6_b = lane_b;
    assign a7_b = lane_b;

    assign err     = err_q;
    assign blk_cnt = blk_cnt_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= COLLECT;
            idx_q     <= 3'd0;
            row_cnt_q <= '0;
            blk_cnt_q <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            row_cnt_q <= row_cnt_d;
            blk_cnt_q <= blk_cnt_d;
            err_q     <= err_d;
        end
    end

    // Pixel storage is data only; it is only read while EMIT is active.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 8; i++) pix_q[i] <= pix_d[i];
    end

endmodule

// File: tb/tb_tpose_row_serialize.sv
// Randomized bench for tpose_row_serialize: two instances (SHIFT=0 and SHIFT=3)
// share stimulus and are compared every cycle against a queue-based model.
module tb_tpose_row_serialize;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic signed [15:0] in_d [8];
    logic [7:0]         in_v, in_e;
    logic               ob;

    logic [7:0]  ab0, ab1;
    logic [7:0]  od0, od1;
    logic        oe0, oe1, ov0, ov1, er0, er1;
    logic [15:0] bc0, bc1;

    int checks = 0;
    int failures = 0;

    // Model: raw samples awaiting output, plus end-of-stream / done / error flags.
    int q[$];
    int pops, rows_m, blks_m;
    bit eos_p, done_m, err_m, armed;
    bit exp_take;
    int ob_pct;

    tpose_row_serialize #(.SHIFT(0)) dut (
        .clock(clk), .reset(rst_n),
        .a0_d(in_d[0]), .a0_e(in_e[0]), .a0_v(in_v[0]), .a0_b(ab0[0]),
        .a1_d(in_d[1]), .a1_e(in_e[1]), .a1_v(in_v[1]), .a1_b(ab0[1]),
        .a2_d(in_d[2]), .a2_e(in_e[2]), .a2_v(in_v[2]), .a2_b(ab0[2]),
        .a3_d(in_d[3]), .a3_e(in_e[3]), .a3_v(in_v[3]), .a3_b(ab0[3]),
        .a4_d(in_d[4]), .a4_e(in_e[4]), .a4_v(in_v[4]), .a4_b(ab0[4]),
        .a5_d(in_d[5]), .a5_e(in_e[5]), .a5_v(in_v[5]), .a5_b(ab0[5]),
        .a6_d(in_d[6]), .a6_e(in_e[6]), .a6_v(in_v[6]), .a6_b(ab0[6]),
        .a7_d(in_d[7]), .a7_e(in_e[7]), .a7_v(in_v[7]), .a7_b(ab0[7]),
        .o_d(od0), .o_e(oe0), .o_v(ov0), .o_b(ob), .err(er0), .blk_cnt(bc0)
    );

    tpose_row_serialize #(.SHIFT(3)) dut3 (
        .clock(clk), .reset(rst_n),
        .a0_d(in_d[0]), .a0_e(in_e[0]), .a0_v(in_v[0]), .a0_b(ab1[0]),
        .a1_d(in_d[1]), .a1_e(in_e[1]), .a1_v(in_v[1]), .a1_b(ab1[1]),
        .a2_d(in_d[2]), .a2_e(in_e[2]), .a2_v(in_v[2]), .a2_b(ab1[2]),
        .a3_d(in_d[3]), .a3_e(in_e[3]), .a3_v(in_v[3]), .a3_b(ab1[3]),
        .a4_d(in_d[4]), .a4_e(in_e[4]), .a4_v(in_v[4]), .a4_b(ab1[4]),
        .a5_d(in_d[5]), .a5_e(in_e[5]), .a5_v(in_v[5]), .a5_b(ab1[5]),
        .a6_d(in_d[6]), .a6_e(in_e[6]), .a6_v(in_v[6]), .a6_b(ab1[6]),
        .a7_d(in_d[7]), .a7_e(in_e[7]), .a7_v(in_v[7]), .a7_b(ab1[7]),
        .o_d(od1), .o_e(oe1), .o_v(ov1), .o_b(ob), .err(er1), .blk_cnt(bc1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_pix(input int x, input int sh);
        int r;
        r = (sh > 0) ? ((x + (1 << (sh - 1))) >>> sh) : x;
        r = r + 128;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    function automatic int rnd_sample();
        logic signed [15:0] s;
        if ($urandom_range(3) == 0) begin
            s = 16'($urandom);
            return int'(s);
        end
        return int'($urandom_range(600)) - 300;
    endfunction

    // Called just after a negedge with inputs set; checks, advances the model, waits a cycle.
    task automatic step();
        bit allv, alle0, alle1, can;
        int eov, eoe, eod0, eod3, eab;
        #1;
        allv  = &in_v;
        alle0 = ~(|in_e);
        alle1 = &in_e;
        can = !done_m && !err_m && !eos_p && (q.size() == 0 || (q.size() == 1 && !ob));
        exp_take = rst_n && can && allv && (alle0 || alle1);
        eab  = exp_take ? 0 : 255;
        eov  = (q.size() > 0 || eos_p) ? 1 : 0;
        eoe  = (q.size() == 0 && eos_p) ? 1 : 0;
        eod0 = (q.size() > 0) ? ref_pix(q[0], 0) : 0;
        eod3 = (q.size() > 0) ? ref_pix(q[0], 3) : 0;
        if (armed) begin
            check_eq("lane_b", ab0, eab);
            check_eq("o_v", ov0, eov);
            check_eq("o_e", oe0, eoe);
            check_eq("o_d", od0, eod0);
            check_eq("err", er0, err_m);
            check_eq("blk_cnt", bc0, blks_m & 16'hffff);
            check_eq("s3_lane_b", ab1, eab);
            check_eq("s3_o_v", ov1, eov);
            check_eq("s3_o_e", oe1, eoe);
            check_eq("s3_o_d", od1, eod3);
            check_eq("s3_err", er1, err_m);
            check_eq("s3_blk_cnt", bc1, blks_m & 16'hffff);
        end
        if (!rst_n) begin
            q.delete();
            pops = 0; rows_m = 0; blks_m = 0;
            eos_p = 0; done_m = 0; err_m = 0;
            armed = 1;
        end else begin
            if (eov == 1 && !ob) begin
                if (q.size() > 0) begin
                    void'(q.pop_front());
                    pops++;
                    if (pops % 8 == 0) begin
                        rows_m++;
                        if (rows_m == 8) begin
                            rows_m = 0;
                            blks_m++;
                        end
                    end
                end else begin
                    eos_p = 0;
                    done_m = 1;
                end
            end
            if (can && allv) begin
                if (alle0) for (int i = 0; i < 8; i++) q.push_back(int'(in_d[i]));
                else if (alle1) eos_p = 1;
                else err_m = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic offer(input int v[8], input logic [7:0] e, input string tag);
        bit got = 0;
        for (int i = 0; i < 8; i++) in_d[i] = 16'(v[i]);
        in_v = 8'hff;
        in_e = e;
        for (int c = 0; c < 200 && !got; c++) begin
            ob = ($urandom_range(99) < ob_pct);
            step();
            got = exp_take;
        end
        if (!got) check_eq({tag, "_timeout"}, 0, 1);
        in_v = 8'h00;
        in_e = 8'h00;
    endtask

    task automatic drain(input string tag);
        int c = 0;
        in_v = 8'h00;
        while ((q.size() > 0 || eos_p) && c < 500) begin
            ob = ($urandom_range(99) < ob_pct);
            step();
            c++;
        end
        if (c >= 500) check_eq({tag, "_drain_timeout"}, 0, 1);
        ob = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    function automatic void rand_row(output int v[8]);
        for (int i = 0; i < 8; i++) v[i] = rnd_sample();
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r1[8] = '{-128, 0, 127, -200, 200, 5, -5, 1};
        int l1[8] = '{0, 128, 255, 0, 255, 133, 123, 129};
        int r2[8] = '{12, -13, -12, 0, 0, 0, 0, 0};
        int l2[3] = '{130, 126, 127}; // -13 rounds half-up from -1.625 to -2
        int ra[8], rb[8];

        rst_n = 1'b0; ob = 1'b0; in_v = 8'h00; in_e = 8'h00; ob_pct = 0;
        for (int i = 0; i < 8; i++) in_d[i] = 16'sd0;
        armed = 0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        check_eq("rst_o_v", ov0, 0);
        check_eq("rst_err", er0, 0);
        check_eq("rst_blk_cnt", bc0, 0);

        // Directed row, SHIFT=0 literals.
        offer(r1, 8'h00, "row1");
        for (int k = 0; k < 8; k++) begin
            check_eq("row1_px", od0, l1[k]);
            step();
        end
        drain("row1");

        // Directed row, SHIFT=3 literals.
        offer(r2, 8'h00, "row2");
        for (int k = 0; k < 3; k++) begin
            check_eq("row2_s3_px", od1, l2[k]);
            step();
        end
        drain("row2");

        // Back-to-back rows with no backpressure.
        rand_row(ra); rand_row(rb);
        offer(ra, 8'h00, "b2b_a");
        offer(rb, 8'h00, "b2b_b");
        drain("b2b");

        // Backpressure at idx=3 while the next row waits.
        rand_row(ra); rand_row(rb);
        offer(ra, 8'h00, "hold_a");
        for (int i = 0; i < 8; i++) in_d[i] = 16'(rb[i]);
        in_v = 8'hff;
        ob = 1'b0;
        for (int i = 0; i < 3; i++) step();
        ob = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_eq("hold_px", od0, ref_pix(ra[3], 0));
        check_eq("hold_ov", ov0, 1);
        check_eq("hold_lane_b", ab0, 255);
        offer(rb, 8'h00, "hold_b");
        drain("hold");

        // Random traffic: partial validity, random data and backpressure.
        ob_pct = 30;
        for (int c = 0; c < 600; c++) begin
            in_v = ($urandom_range(9) < 7) ? 8'hff : 8'($urandom);
            in_e = 8'h00;
            for (int i = 0; i < 8; i++) in_d[i] = 16'(rnd_sample());
            ob = ($urandom_range(99) < ob_pct);
            step();
        end
        drain("rand");

        // One full block then end of stream.
        pulse_reset();
        ob_pct = 20;
        for (int r = 0; r < 8; r++) begin
            rand_row(ra);
            offer(ra, 8'h00, "blk");
        end
        rand_row(ra);
        offer(ra, 8'hff, "eos");
        drain("eos");
        check_eq("blk_cnt_one", bc0, 1);
        rand_row(ra);
        for (int i = 0; i < 8; i++) in_d[i] = 16'(ra[i]);
        in_v = 8'hff;
        ob = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_eq("done_ov", ov0, 0);
        check_eq("done_lane_b", ab0, 255);
        in_v = 8'h00;

        // Lane mismatch sets sticky err.
        pulse_reset();
        in_v = 8'hff;
        in_e = 8'h10;
        step();
        check_eq("mm_err", er0, 1);
        for (int i = 0; i < 4; i++) step();
        in_v = 8'h00;
        in_e = 8'h00;

        // Reset in the middle of a row, then a fresh row.
        pulse_reset();
        ob_pct = 0;
        rand_row(ra);
        offer(ra, 8'h00, "mid");
        step();
        step();
        pulse_reset();
        check_eq("mid_rst_ov", ov0, 0);
        check_eq("mid_rst_err", er0, 0);
        check_eq("mid_rst_blk", bc0, 0);
        rand_row(rb);
        offer(rb, 8'h00, "fresh");
        check_eq("fresh_px0", od0, ref_pix(rb[0], 0));
        drain("fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
